pokey_bus_master: RTL and testbench

//  CPU-side bus initiator that drives the POKEY register interface (en, rw, a[3:0], d[7:0]).

---
 rtl/pokey_bus_master.sv | 184 ++++++++++++++++++
 tb/tb_pokey_bus_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pokey_bus_master.sv
// Host-side bus initiator for POKEY: queues register commands in a 2-entry FIFO and
// plays each one out as a SETUP / STROBE / HOLD bus cycle, returning read data on a stream.
module pokey_bus_master #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       en,
    output logic       rw,
    output logic [3:0] a,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in,
    input  logic       irq,
    output logic       irq_sync,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RESP
    } state_t;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [12:0] fifo_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q;
    logic        push, pop, full, empty;
    logic [12:0] head;

    logic        rw_q;
    logic [3:0]  a_q;
    logic [7:0]  d_q;
    logic [7:0]  rdata_q;
    logic        capture;
    logic        bus_active;
    logic [1:0]  irq_q;

    // ---------------- command FIFO ----------------
    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = fifo_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {cmd_rw, cmd_addr, cmd_wdata};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    // ---------------- bus-cycle sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    capture = rw_q;
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = rw_q ? S_RESP : S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Address/rw/data only load when a command is popped, so they are stable across the cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q    <= 1'b1;
            a_q     <= '0;
            d_q     <= '0;
            rdata_q <= '0;
        end else begin
            if (pop) begin
                rw_q <= head[12];
                a_q  <= head[11:8];
                d_q  <= head[7:0];
            end
            if (capture) begin
                rdata_q <= d_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 2'b11;
        end else begin
            irq_q <= {irq_q[0], irq};
        end
    end

    // ---------------- outputs ----------------
    assign bus_active = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
    assign en         = (state_q == S_STROBE);
    assign rw         = bus_active ? rw_q : 1'b1;
    assign d_oe       = bus_active && !rw_q;
    assign a          = a_q;
    assign d_out      = d_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_rdata  = rdata_q;
    assign irq_sync   = irq_q[1];
    assign busy       = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_pokey_bus_master.sv
// Directed bench for pokey_bus_master: default timing plus (1,1,1) and (3,4,2) variants.
module tb_pokey_bus_master;

    localparam int unsigned SP [3] = '{1, 1, 3};
    localparam int unsigned TP [3] = '{2, 1, 4};
    localparam int unsigned HP [3] = '{1, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_rw;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [7:0] d_in;
    logic       irq;

    logic       cv [3];
    logic       rr [3];
    logic       cr [3];
    logic       rv [3];
    logic       en [3];
    logic       rw [3];
    logic       oe [3];
    logic       irs [3];
    logic       busy [3];
    logic [7:0] rdata [3];
    logic [7:0] dout [3];
    logic [3:0] a [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pokey_bus_master #(
            .SETUP_CYC (SP[g]),
            .STROBE_CYC(TP[g]),
            .HOLD_CYC  (HP[g])
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .cmd_valid(cv[g]),
            .cmd_ready(cr[g]),
            .cmd_rw   (cmd_rw),
            .cmd_addr (cmd_addr),
            .cmd_wdata(cmd_wdata),
            .rsp_valid(rv[g]),
            .rsp_ready(rr[g]),
            .rsp_rdata(rdata[g]),
            .en       (en[g]),
            .rw       (rw[g]),
            .a        (a[g]),
            .d_out    (dout[g]),
            .d_oe     (oe[g]),
            .d_in     (d_in),
            .irq      (irq),
            .irq_sync (irs[g]),
            .busy     (busy[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] addrs [4];
        logic       acc;
        int unsigned p, idx;
        logic        exp_en, exp_rv;

        for (int i = 0; i < 3; i++) begin
            cv[i] = 1'b0;
            rr[i] = 1'b0;
        end
        cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0; d_in = '0; irq = 1'b1;

        // reset values, sampled while rst_n is low
        #23;
        check("rst_en", en[0], 1'b0);
        check("rst_rw", rw[0], 1'b1);
        check("rst_a", a[0], 4'h0);
        check("rst_dout", dout[0], 8'h00);
        check("rst_oe", oe[0], 1'b0);
        check("rst_rv", rv[0], 1'b0);
        check("rst_rdata", rdata[0], 8'h00);
        check("rst_irq", irs[0], 1'b1);
        check("rst_busy", busy[0], 1'b0);
        check("rst_ready", cr[0], 1'b1);
        rst_n = 1'b1;
        step();

        // 1. write a=8 d=50
        cmd_rw = 1'b0; cmd_addr = 4'h8; cmd_wdata = 8'h50; cv[0] = 1'b1;
        step();
        cv[0] = 1'b0;
        check("w_n0_busy", busy[0], 1'b1);
        check("w_n0_en", en[0], 1'b0);
        step();
        check("w_setup_en", en[0], 1'b0);
        check("w_setup_rw", rw[0], 1'b0);
        check("w_setup_oe", oe[0], 1'b1);
        check("w_setup_a", a[0], 4'h8);
        check("w_setup_d", dout[0], 8'h50);
        step();
        check("w_strobe1_en", en[0], 1'b1);
        step();
        check("w_strobe2_en", en[0], 1'b1);
        check("w_strobe2_oe", oe[0], 1'b1);
        step();
        check("w_hold_en", en[0], 1'b0);
        check("w_hold_oe", oe[0], 1'b1);
        check("w_hold_rw", rw[0], 1'b0);
        step();
        check("w_idle_oe", oe[0], 1'b0);
        check("w_idle_rw", rw[0], 1'b1);
        check("w_idle_rv", rv[0], 1'b0);
        check("w_idle_busy", busy[0], 1'b0);

        // 2. read a=A, d_in=C3 only during the last strobe clock
        cmd_rw = 1'b1; cmd_addr = 4'hA; d_in = 8'h00; cv[0] = 1'b1;
        step();
        cv[0] = 1'b0;
        step();
        check("r_setup_rw", rw[0], 1'b1);
        check("r_setup_oe", oe[0], 1'b0);
        check("r_setup_a", a[0], 4'hA);
        step();
        check("r_strobe1_en", en[0], 1'b1);
        step();
        check("r_strobe2_en", en[0], 1'b1);
        check("r_strobe2_oe", oe[0], 1'b0);
        d_in = 8'hC3;
        step();
        check("r_hold_en", en[0], 1'b0);
        check("r_hold_rv", rv[0], 1'b0);
        d_in = 8'h5A;
        step();
        check("r_n5_rv", rv[0], 1'b1);
        check("r_n5_rdata", rdata[0], 8'hC3);
        check("r_n5_oe", oe[0], 1'b0);
        check("r_n5_rw", rw[0], 1'b1);
        rr[0] = 1'b1;
        step();
        check("r_hs_rv", rv[0], 1'b0);
        rr[0] = 1'b0;

        // 3. X issued, then A, B pushed back-to-back fill the FIFO; C waits for room
        addrs[0] = 4'h1; addrs[1] = 4'h2; addrs[2] = 4'h3; addrs[3] = 4'h4;
        cmd_rw = 1'b0; cmd_wdata = 8'h11; cmd_addr = addrs[0]; cv[0] = 1'b1;
        step();
        cv[0] = 1'b0;
        step();
        check("q_x_setup_a", a[0], 4'h1);
        cmd_addr = addrs[1]; cv[0] = 1'b1;
        step();
        cmd_addr = addrs[2];
        step();
        check("q_full_ready", cr[0], 1'b0);
        cmd_addr = addrs[3];
        for (int t = 4; t <= 20; t++) begin
            acc = cr[0];
            step();
            if (acc) cv[0] = 1'b0;
            p   = (t - 1) % 5;
            idx = (t - 1) / 5;
            exp_en = (p == 1) || (p == 2);
            check("q_en", en[0], exp_en);
            check("q_oe", oe[0], p != 4);
            if (p != 4) check("q_a", a[0], addrs[idx]);
        end
        check("q_end_busy", busy[0], 1'b0);
        check("q_end_cv", cv[0], 1'b0);

        // 4. read held in RESP for 10 clocks while a write waits
        cmd_rw = 1'b1; cmd_addr = 4'h3; d_in = 8'h96; cv[0] = 1'b1;
        step();
        cmd_rw = 1'b0; cmd_addr = 4'h5; cmd_wdata = 8'h77;
        step();
        cv[0] = 1'b0;
        step(); step(); step(); step();
        check("bp_rv", rv[0], 1'b1);
        check("bp_rdata", rdata[0], 8'h96);
        d_in = 8'h00;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_rv", rv[0], 1'b1);
            check("bp_hold_rdata", rdata[0], 8'h96);
            check("bp_hold_en", en[0], 1'b0);
            check("bp_hold_a", a[0], 4'h3);
        end
        rr[0] = 1'b1;
        step();
        rr[0] = 1'b0;
        check("bp_hs_rv", rv[0], 1'b0);
        check("bp_hs_a", a[0], 4'h3);
        step();
        check("bp_w_a", a[0], 4'h5);
        check("bp_w_rw", rw[0], 1'b0);
        check("bp_w_d", dout[0], 8'h77);
        step(); step(); step(); step();
        check("bp_w_busy", busy[0], 1'b0);

        // 5. reset asserted mid-strobe of a write, second command queued
        cmd_rw = 1'b0; cmd_addr = 4'h6; cmd_wdata = 8'hAA; cv[0] = 1'b1;
        step();
        cmd_addr = 4'h7;
        step();
        cv[0] = 1'b0;
        step();
        check("rs_strobe_en", en[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_en", en[0], 1'b0);
        check("rs_oe", oe[0], 1'b0);
        #2 rst_n = 1'b1;
        step();
        check("rs_busy", busy[0], 1'b0);
        check("rs_ready", cr[0], 1'b1);
        check("rs_after_en", en[0], 1'b0);
        step();
        check("rs_after_busy", busy[0], 1'b0);

        // 6a. irq synchroniser latency
        irq = 1'b0;
        step();
        check("irq_1clk", irs[0], 1'b1);
        step();
        check("irq_2clk", irs[0], 1'b0);
        irq = 1'b1;
        step();
        check("irq_rise_1clk", irs[0], 1'b0);
        step();
        check("irq_rise_2clk", irs[0], 1'b1);

        // 6b. non-default timing: en window and rsp latency against the latency formula
        cmd_rw = 1'b1; cmd_addr = 4'h9; d_in = 8'h3C;
        cv[1] = 1'b1; cv[2] = 1'b1;
        step();
        cv[1] = 1'b0; cv[2] = 1'b0;
        for (int t = 1; t <= 11; t++) begin
            step();
            for (int g = 1; g < 3; g++) begin
                exp_en = (t >= 1 + SP[g]) && (t < 1 + SP[g] + TP[g]);
                exp_rv = (t >= 1 + SP[g] + TP[g] + HP[g]);
                check(g == 1 ? "p111_en" : "p342_en", en[g], exp_en);
                check(g == 1 ? "p111_rv" : "p342_rv", rv[g], exp_rv);
            end
        end
        check("p111_rdata", rdata[1], 8'h3C);
        check("p342_rdata", rdata[2], 8'h3C);
        rr[1] = 1'b1; rr[2] = 1'b1;
        step();
        check("p111_hs", rv[1], 1'b0);
        check("p342_hs", rv[2], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
